// File: rtl/spi_axil_cmd_master.sv
// Command FIFO feeding a single-outstanding AXI4-Lite master toward the spi_intface slave port.
// Completions (read data or timeout error) are returned in strict command order.
module spi_axil_cmd_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              S_SYSCLK,
    input  logic              S_RESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WR,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [31:0]       CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic [ADDR_W-1:0] M_AWADDR,
    output logic              M_AWVALID,
    input  logic              M_AWREADY,
    output logic [31:0]       M_WDATA,
    output logic              M_WVALID,
    input  logic              M_WREADY,
    input  logic              M_BVALID,
    output logic              M_BREADY,
    output logic [ADDR_W-1:0] M_ARADDR,
    output logic              M_ARVALID,
    input  logic              M_ARREADY,
    input  logic [31:0]       M_RDATA,
    input  logic              M_RVALID,
    output logic              M_RREADY
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic              fifo_wr   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, empty, push, pop;

    logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic              rsp_valid_d, rsp_err_d;
    logic [31:0]       rsp_rdata_d, wdata_d;
    logic [ADDR_W-1:0] awaddr_d, araddr_d;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign CMD_READY = !full;
    assign push      = CMD_VALID && !full;

    always_ff @(posedge S_SYSCLK) begin
        if (push) begin
            fifo_wr[wr_ptr]   <= CMD_WR;
            fifo_addr[wr_ptr] <= CMD_ADDR;
            fifo_data[wr_ptr] <= CMD_WDATA;
        end
    end

    always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
        if (S_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
        if (S_RESET) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            M_AWVALID <= 1'b0;
            M_WVALID  <= 1'b0;
            M_BREADY  <= 1'b0;
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b0;
            M_AWADDR  <= '0;
            M_WDATA   <= '0;
            M_ARADDR  <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            M_AWVALID <= awvalid_d;
            M_WVALID  <= wvalid_d;
            M_BREADY  <= bready_d;
            M_ARVALID <= arvalid_d;
            M_RREADY  <= rready_d;
            M_AWADDR  <= awaddr_d;
            M_WDATA   <= wdata_d;
            M_ARADDR  <= araddr_d;
            RSP_VALID <= rsp_valid_d;
            RSP_RDATA <= rsp_rdata_d;
            RSP_ERR   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pop         = 1'b0;
        awvalid_d   = M_AWVALID;
        wvalid_d    = M_WVALID;
        bready_d    = M_BREADY;
        arvalid_d   = M_ARVALID;
        rready_d    = M_RREADY;
        awaddr_d    = M_AWADDR;
        wdata_d     = M_WDATA;
        araddr_d    = M_ARADDR;
        rsp_valid_d = RSP_VALID;
        rsp_rdata_d = RSP_RDATA;
        rsp_err_d   = RSP_ERR;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (fifo_wr[rd_ptr]) begin
                        state_d   = WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = fifo_addr[rd_ptr];
                        wdata_d   = fifo_data[rd_ptr];
                    end else begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                        araddr_d  = fifo_addr[rd_ptr];
                    end
                end
            end
            WADDR: begin
                // AW and W retire independently; move on once both next-values are low
                if (M_AWVALID && M_AWREADY) awvalid_d = 1'b0;
                if (M_WVALID && M_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                    timer_d  = '0;
                end
            end
            WRESP: begin
                if (M_BVALID && M_BREADY) begin
                    state_d     = RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d     = RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RADDR: begin
                if (M_ARVALID && M_ARREADY) begin
                    state_d   = RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    timer_d   = '0;
                end
            end
            RDATA: begin
                if (M_RVALID && M_RREADY) begin
                    state_d     = RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = M_RDATA;
                    rsp_err_d   = 1'b0;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d     = RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RSP: begin
                if (RSP_READY) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_axil_cmd_master.sv
// Directed bench for spi_axil_cmd_master: a latency-configurable AXI-Lite slave model
// plus handshake monitors; inputs change 1 time unit after the rising edge, monitors sample on the falling edge.
module tb_spi_axil_cmd_master;

    logic        S_SYSCLK = 1'b0;
    logic        S_RESET;
    logic        CMD_VALID, CMD_READY, CMD_WR;
    logic [7:0]  CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic        RSP_VALID, RSP_READY, RSP_ERR;
    logic [31:0] RSP_RDATA;
    logic [7:0]  M_AWADDR, M_ARADDR;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY;
    logic [31:0] M_WDATA, M_RDATA;
    logic        M_RVALID, M_RREADY;

    spi_axil_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(255), .ADDR_W(8)) dut (
        .S_SYSCLK(S_SYSCLK), .S_RESET(S_RESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    always #5 S_SYSCLK = ~S_SYSCLK;

    int total = 0;
    int bad   = 0;

    // slave model configuration
    int unsigned aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic        b_never = 1'b0;
    logic [31:0] rd_base = '0;

    // monitor state
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs, accepted, split_cnt, bready_cycles;
    logic [7:0]  aw_addr_seen, ar_addr_seen;
    logic [31:0] w_data_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        accepted = 0; split_cnt = 0; bready_cycles = 0;
    endtask

    task automatic tick();
        @(posedge S_SYSCLK);
        #1;
    endtask

    task automatic push(input logic wr, input logic [7:0] addr, input logic [31:0] data);
        int unsigned n = 0;
        CMD_WR = wr; CMD_ADDR = addr; CMD_WDATA = data; CMD_VALID = 1'b1;
        while (!CMD_READY && n < 100) begin
            tick();
            n++;
        end
        chk("cmd_ready", 32'(CMD_READY), 32'd1);
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_data, input logic exp_err);
        int unsigned n = 0;
        while (!RSP_VALID && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(RSP_VALID), 32'd1);
        if (RSP_VALID) begin
            chk({tag, "_data"}, RSP_RDATA, exp_data);
            chk({tag, "_err"}, 32'(RSP_ERR), 32'(exp_err));
            RSP_READY = 1'b1;
            tick();
            RSP_READY = 1'b0;
            chk({tag, "_drop"}, 32'(RSP_VALID), 32'd0);
        end
    endtask

    always @(negedge S_SYSCLK) begin
        if (M_AWVALID && M_AWREADY) begin aw_hs++; aw_addr_seen = M_AWADDR; end
        if (M_WVALID && M_WREADY) begin w_hs++; w_data_seen = M_WDATA; end
        if (M_BVALID && M_BREADY) b_hs++;
        if (M_ARVALID && M_ARREADY) begin ar_hs++; ar_addr_seen = M_ARADDR; end
        if (M_RVALID && M_RREADY) r_hs++;
        if (CMD_VALID && CMD_READY) accepted++;
        if (M_AWVALID && !M_WVALID) split_cnt++;
        if (M_BREADY) bready_cycles++;
    end

    int unsigned aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    initial begin
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0;
        forever begin
            tick();
            if (M_AWVALID) begin M_AWREADY = (aw_wait >= aw_lat); aw_wait++; end
            else begin M_AWREADY = 1'b0; aw_wait = 0; end
            if (M_WVALID) begin M_WREADY = (w_wait >= w_lat); w_wait++; end
            else begin M_WREADY = 1'b0; w_wait = 0; end
            if (M_BREADY && !b_never) begin M_BVALID = (b_wait >= b_lat); b_wait++; end
            else begin M_BVALID = 1'b0; b_wait = 0; end
            if (M_ARVALID) begin M_ARREADY = (ar_wait >= ar_lat); ar_wait++; end
            else begin M_ARREADY = 1'b0; ar_wait = 0; end
            if (M_RREADY) begin
                M_RVALID = (r_wait >= r_lat);
                M_RDATA  = M_RVALID ? rd_base + {24'h0, ar_addr_seen} : '0;
                r_wait++;
            end else begin
                M_RVALID = 1'b0; M_RDATA = '0; r_wait = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        S_RESET = 1'b1; CMD_VALID = 1'b0; CMD_WR = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
        RSP_READY = 1'b0;
        clear_mon();
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("rst_awvalid",   32'(M_AWVALID), 32'd0);
        chk("rst_wvalid",    32'(M_WVALID),  32'd0);
        chk("rst_arvalid",   32'(M_ARVALID), 32'd0);
        chk("rst_bready",    32'(M_BREADY),  32'd0);
        chk("rst_rready",    32'(M_RREADY),  32'd0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        S_RESET = 1'b0;
        repeat (2) tick();

        // plain write, BVALID two cycles after BREADY rises
        clear_mon();
        b_lat = 2;
        push(1'b1, 8'h00, 32'h8000_0000);
        chk("issue_lat0", 32'(M_AWVALID), 32'd0);
        tick();
        chk("issue_lat1", 32'(M_AWVALID), 32'd1);
        wait_rsp("wr1", 32'h0, 1'b0);
        chk("wr1_aw_hs", aw_hs, 1);
        chk("wr1_w_hs",  w_hs,  1);
        chk("wr1_b_hs",  b_hs,  1);
        chk("wr1_awaddr", 32'(aw_addr_seen), 32'h00);
        chk("wr1_wdata",  w_data_seen, 32'h8000_0000);

        // W accepted three cycles before AW
        clear_mon();
        b_lat = 0; w_lat = 0; aw_lat = 3;
        push(1'b1, 8'h04, 32'hDEAD_BEEF);
        wait_rsp("wr2", 32'h0, 1'b0);
        chk("wr2_aw_hs", aw_hs, 1);
        chk("wr2_w_hs",  w_hs,  1);
        chk("wr2_split", split_cnt, 3);
        chk("wr2_wdata", w_data_seen, 32'hDEAD_BEEF);
        aw_lat = 0;

        // read, RVALID five cycles after ARREADY
        clear_mon();
        r_lat = 4; rd_base = 32'h1122_3338;
        push(1'b0, 8'h0C, 32'h0);
        wait_rsp("rd1", 32'h1122_3344, 1'b0);
        chk("rd1_ar_hs", ar_hs, 1);
        chk("rd1_r_hs",  r_hs,  1);
        r_lat = 0;

        // six back-to-back commands with responses held off
        clear_mon();
        rd_base = 32'hCAFE_0000;
        push(1'b0, 8'h10, 32'h0);
        push(1'b0, 8'h11, 32'h0);
        push(1'b1, 8'h12, 32'h5);
        push(1'b0, 8'h13, 32'h0);
        push(1'b0, 8'h14, 32'h0);
        fork
            push(1'b0, 8'h15, 32'h0);
            begin
                repeat (20) tick();
                chk("fill_accepted", accepted, 5);
                chk("fill_stall", 32'(CMD_READY), 32'd0);
                wait_rsp("q1", 32'hCAFE_0010, 1'b0);
            end
        join
        wait_rsp("q2", 32'hCAFE_0011, 1'b0);
        wait_rsp("q3", 32'h0, 1'b0);
        wait_rsp("q4", 32'hCAFE_0013, 1'b0);
        wait_rsp("q5", 32'hCAFE_0014, 1'b0);
        wait_rsp("q6", 32'hCAFE_0015, 1'b0);
        chk("fill_total", accepted, 6);

        // write whose response never arrives, followed by a queued read
        clear_mon();
        b_never = 1'b1; rd_base = '0;
        push(1'b1, 8'h20, 32'h1234_5678);
        push(1'b0, 8'h21, 32'h0);
        wait_rsp("to_wr", 32'h0, 1'b1);
        chk("to_bready_cycles", bready_cycles, 255);
        chk("to_b_hs", b_hs, 0);
        b_never = 1'b0;
        wait_rsp("to_rd", 32'h21, 1'b0);

        // reset pulsed while waiting for read data
        clear_mon();
        r_lat = 1000;
        push(1'b0, 8'h30, 32'h0);
        push(1'b1, 8'h31, 32'h1);
        push(1'b1, 8'h32, 32'h2);
        for (int i = 0; i < 20 && !M_RREADY; i++) tick();
        chk("rr_rready_up", 32'(M_RREADY), 32'd1);
        #2;
        S_RESET = 1'b1;
        #1;
        chk("rr_rready",    32'(M_RREADY),  32'd0);
        chk("rr_arvalid",   32'(M_ARVALID), 32'd0);
        chk("rr_awvalid",   32'(M_AWVALID), 32'd0);
        chk("rr_wvalid",    32'(M_WVALID),  32'd0);
        chk("rr_bready",    32'(M_BREADY),  32'd0);
        chk("rr_rsp_valid", 32'(RSP_VALID), 32'd0);
        repeat (2) tick();
        S_RESET = 1'b0;
        r_lat = 0;
        clear_mon();
        repeat (5) tick();
        chk("rr_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("rr_no_aw", aw_hs, 0);
        chk("rr_no_ar", ar_hs, 0);
        chk("rr_idle_aw", 32'(M_AWVALID), 32'd0);
        push(1'b0, 8'h40, 32'h0);
        wait_rsp("rr_resume", 32'h40, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
